// File: rtl/seq_detect_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_detect_param : serial pattern detector with a loadable pattern and length,
//                    overlap control, and a saturating match counter. Rev 1.0
// ---------------------------------------------------------------------------
module seq_detect_param #(
  parameter int MAXLEN = 8,
  parameter int CNTW   = 16,
  localparam int LW    = $clog2(MAXLEN + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              I,
  input  logic              en,
  input  logic              load,
  input  logic [MAXLEN-1:0] pat_in,
  input  logic [LW-1:0]     len_in,
  input  logic              overlap,
  input  logic              count_clr,
  output logic              F,
  output logic [CNTW-1:0]   match_count,
  output logic              cfg_err
);

  localparam logic [LW-1:0]     MAX_FILL = LW'(MAXLEN);
  localparam logic [LW-1:0]     RST_LEN  = LW'(4);
  localparam logic [MAXLEN-1:0] RST_PAT  = MAXLEN'(4'b1001);
  localparam logic [CNTW-1:0]   CNT_MAX  = {CNTW{1'b1}};

  logic [MAXLEN-1:0] pat_q, pat_d;
  logic [MAXLEN-1:0] hist_q, hist_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     fill_q, fill_d;
  logic              f_q, f_d;
  logic              cfg_err_q, cfg_err_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;

  logic [MAXLEN-1:0] hist_shift;
  logic [MAXLEN-1:0] len_mask;
  logic [LW:0]       fill_p1;
  logic [LW-1:0]     fill_sat;
  logic              len_ok;
  logic              enough;
  logic              match;

  // Match evaluation against the history as it will be after this edge's shift
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAXLEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    hist_shift = {hist_q[MAXLEN-2:0], I};
    fill_p1    = {1'b0, fill_q} + {{LW{1'b0}}, 1'b1};
    fill_sat   = (fill_q == MAX_FILL) ? MAX_FILL : fill_p1[LW-1:0];
    enough     = (fill_p1 >= {1'b0, len_q});
    len_ok     = (len_in != '0) && (len_in <= MAX_FILL);
    match      = en && !load && enough &&
                 ((hist_shift & len_mask) == (pat_q & len_mask));
  end

  always_comb begin
    pat_d     = pat_q;
    len_d     = len_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    f_d       = 1'b0;
    cfg_err_d = 1'b0;
    if (load) begin
      if (len_ok) begin
        pat_d  = pat_in;
        len_d  = len_in;
        hist_d = '0;
        fill_d = '0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (en) begin
      hist_d = hist_shift;
      f_d    = match;
      // Non-overlapping mode: the next match must be built from fresh bits only
      fill_d = (match && !overlap) ? '0 : fill_sat;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (count_clr) begin
      cnt_d = '0;
    end else if (match && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pat_q     <= RST_PAT;
      len_q     <= RST_LEN;
      hist_q    <= '0;
      fill_q    <= '0;
      f_q       <= 1'b0;
      cfg_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pat_q     <= pat_d;
      len_q     <= len_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      f_q       <= f_d;
      cfg_err_q <= cfg_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign F           = f_q;
  assign match_count = cnt_q;
  assign cfg_err     = cfg_err_q;

endmodule
`default_nettype wire
